// File: rtl/cor_h_x_pkg.sv
// cor_h_x_pkg -- shared definitions for the backward-filter (cor_h_x) block
// and its convolve sibling.
//   L_SUBFR  : subframe length in samples
//   MAX_32   : most positive 32-bit fractional value
//   MIN_32   : most negative 32-bit fractional value
//   state_e  : sequencer state encoding
//   sat_33to32 : clamp a 33-bit two's-complement sum into 32 bits
package cor_h_x_pkg;

  localparam int          L_SUBFR = 40;
  localparam logic [31:0] MAX_32  = 32'h7FFF_FFFF;
  localparam logic [31:0] MIN_32  = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RD_X  = 3'd2,
    RD_H  = 3'd3,
    MAC   = 3'd4,
    WRITE = 3'd5,
    DONE  = 3'd6
  } state_e;

  // Bits 32 and 31 differ only when the true sum left the 32-bit range;
  // bit 32 then carries the real sign.
  function automatic logic [31:0] sat_33to32(input logic [32:0] sum);
    logic [31:0] res;
    if (sum[32] != sum[31]) begin
      res = sum[32] ? MIN_32 : MAX_32;
    end else begin
      res = sum[31:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/cor_h_x_if.sv
// cor_h_x_if -- control and scratch-memory bus of the cor_h_x block.
//   start, xAddr, hAddr, yAddr : pass request and vector base addresses
//   memReadAddr / memIn        : read port, data returned one cycle later
//   memWriteAddr / memOut / memWriteEn : write port
//   done                       : one-cycle end-of-pass pulse
// The master modport is the cor_h_x block (it masters the memory bus);
// the slave modport is the environment (controller plus memory).
interface cor_h_x_if #(
  parameter int AW = 12
);
  logic          start;
  logic [AW-1:0] xAddr;
  logic [AW-1:0] hAddr;
  logic [AW-1:0] yAddr;
  logic [AW-1:0] memReadAddr;
  logic [31:0]   memIn;
  logic [AW-1:0] memWriteAddr;
  logic [31:0]   memOut;
  logic          memWriteEn;
  logic          done;

  modport master (
    input  start, xAddr, hAddr, yAddr, memIn,
    output memReadAddr, memWriteAddr, memOut, memWriteEn, done
  );

  modport slave (
    output start, xAddr, hAddr, yAddr, memIn,
    input  memReadAddr, memWriteAddr, memOut, memWriteEn, done
  );
endinterface

// File: rtl/cor_h_x_l_mac_sat.sv
// l_mac_sat -- combinational saturating fractional multiply-accumulate.
//   acc_i : 32-bit accumulator in
//   a_i   : 16-bit signed operand
//   b_i   : 16-bit signed operand
//   acc_o : sat(acc_i + sat(2*a_i*b_i))
module l_mac_sat
  import cor_h_x_pkg::*;
(
  input  logic signed [31:0] acc_i,
  input  logic signed [15:0] a_i,
  input  logic signed [15:0] b_i,
  output logic signed [31:0] acc_o
);

  logic signed [31:0] prod_s;
  logic        [31:0] dbl_s;
  logic        [32:0] sum_s;

  // Doubled product (only -1 * -1 overflows) followed by saturating add.
  always_comb begin
    prod_s = 32'(a_i) * 32'(b_i);
    if ((a_i == 16'sh8000) && (b_i == 16'sh8000)) begin
      dbl_s = MAX_32;
    end else begin
      dbl_s = {prod_s[30:0], 1'b0};
    end
    sum_s = {acc_i[31], acc_i} + {dbl_s[31], dbl_s};
    acc_o = sat_33to32(sum_s);
  end

endmodule

// File: rtl/cor_h_x.sv
// cor_h_x -- backward filtering: y[n] = extract_h(L_shl(sum_{i=n}^{L-1}
// x[i]*h[i-n], 3)) for n = 0..L-1, all operands in one scratch memory.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : cor_h_x_if master (start/addresses/done plus memory ports)
// One read per cycle: x[i] is fetched in RD_X, h[i-n] in RD_H, and the
// MAC cycle consumes h straight off the read bus.
module cor_h_x
  import cor_h_x_pkg::*;
#(
  parameter int L  = L_SUBFR,
  parameter int AW = 12
) (
  input  logic        clk,
  input  logic        reset,
  cor_h_x_if.master   bus
);

  localparam int CW = $clog2(L);
  localparam logic [CW-1:0] LAST = CW'(L - 1);

  state_e              state_q;
  logic [AW-1:0]       xa_q, ha_q, ya_q;
  logic [CW-1:0]       n_q, i_q;
  logic signed [31:0]  acc_q;
  logic signed [15:0]  x_q;
  logic [AW-1:0]       rd_addr_q, wr_addr_q;
  logic [31:0]         wr_data_q;
  logic                wr_en_q, done_q;

  logic signed [31:0]  acc_d;
  logic [31:0]         shl_d;
  logic [31:0]         out_d;

  l_mac_sat u_mac (
    .acc_i (acc_q),
    .a_i   (x_q),
    .b_i   (bus.memIn[15:0]),
    .acc_o (acc_d)
  );

  // Saturating shift by 3 of the final sum and extraction of its high half.
  // The shift is lossless only when bits 31..28 all equal the sign.
  always_comb begin
    if ((acc_d[31:28] == 4'b0000) || (acc_d[31:28] == 4'b1111)) begin
      shl_d = {acc_d[28:0], 3'b000};
    end else if (acc_d[31]) begin
      shl_d = MIN_32;
    end else begin
      shl_d = MAX_32;
    end
    out_d = {{16{shl_d[31]}}, shl_d[31:16]};
  end

  // Sequencer: counters, accumulator and all registered bus outputs.
  // Outputs are loaded on entry to their state so that memWriteEn is high
  // exactly during WRITE and done exactly during DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      xa_q      <= '0;
      ha_q      <= '0;
      ya_q      <= '0;
      n_q       <= '0;
      i_q       <= '0;
      acc_q     <= '0;
      x_q       <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            xa_q    <= bus.xAddr;
            ha_q    <= bus.hAddr;
            ya_q    <= bus.yAddr;
            n_q     <= '0;
            state_q <= INIT;
          end
        end
        INIT: begin
          acc_q     <= '0;
          i_q       <= n_q;
          rd_addr_q <= xa_q + AW'(n_q);
          state_q   <= RD_X;
        end
        RD_X: begin
          rd_addr_q <= ha_q + AW'(i_q - n_q);
          state_q   <= RD_H;
        end
        RD_H: begin
          x_q     <= bus.memIn[15:0];
          state_q <= MAC;
        end
        MAC: begin
          acc_q <= acc_d;
          if (i_q == LAST) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= ya_q + AW'(n_q);
            wr_data_q <= out_d;
            state_q   <= WRITE;
          end else begin
            i_q       <= i_q + CW'(1);
            rd_addr_q <= xa_q + AW'(i_q + CW'(1));
            state_q   <= RD_X;
          end
        end
        WRITE: begin
          if (n_q == LAST) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            n_q     <= n_q + CW'(1);
            state_q <= INIT;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.memReadAddr  = rd_addr_q;
  assign bus.memWriteAddr = wr_addr_q;
  assign bus.memOut       = wr_data_q;
  assign bus.memWriteEn   = wr_en_q;
  assign bus.done         = done_q;

endmodule
